// File: rtl/park_slot_manager_if.sv
// +----------------------------------------------------------------------------+
// | park_slot_manager_if : request/response and status bundle for the manager  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface park_slot_manager_if #(
  parameter int NUM_SLOTS = 8
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic                 entry_req;
  logic                 entry_vip;
  logic                 exit_req;
  logic [IDX_W-1:0]     exit_slot;
  logic                 entry_ack;
  logic [IDX_W-1:0]     entry_slot;
  logic                 exit_err;
  logic [NUM_SLOTS-1:0] slot_available;
  logic [CNT_W-1:0]     free_count;
  logic                 lot_full;
  logic                 buzzer;

  modport master (
    output entry_req, entry_vip, exit_req, exit_slot,
    input  entry_ack, entry_slot, exit_err, slot_available, free_count, lot_full, buzzer
  );

  modport slave (
    input  entry_req, entry_vip, exit_req, exit_slot,
    output entry_ack, entry_slot, exit_err, slot_available, free_count, lot_full, buzzer
  );
endinterface

`default_nettype wire

// File: rtl/park_slot_manager.sv
// +----------------------------------------------------------------------------+
// | park_slot_manager : parking slot allocator with full-lot buzzer alarm      |
// | Optional feature macro: PARK_RESERVE_EN (top slot reserved for VIP entry)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module park_slot_manager #(
  parameter int NUM_SLOTS    = 8,
  parameter int ALARM_CYCLES = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  park_slot_manager_if.slave bus
);

  localparam int IDX_W  = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);
  localparam int ACNT_W = $clog2(ALARM_CYCLES + 1);
  localparam int SPAN   = 1 << IDX_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ALARM = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [ACNT_W-1:0]    r_acnt, w_acnt_nxt;
  logic [NUM_SLOTS-1:0] r_occ, w_occ_nxt;
  logic                 r_ack, w_ack_nxt;
  logic [IDX_W-1:0]     r_slot, w_slot_nxt;
  logic                 r_err, w_err_nxt;

  logic [SPAN-1:0]      w_occ_span;
  logic                 w_exit_ok;
  logic [NUM_SLOTS-1:0] w_occ_post;
  logic [NUM_SLOTS-1:0] w_cand;
  logic                 w_grant_ok;
  logic [IDX_W-1:0]     w_grant_idx;
  logic [CNT_W-1:0]     w_free;
  logic                 w_lot_full;

  // Zero-padded to the full index range so an out-of-range exit reads as a free slot.
  always_comb begin
    w_occ_span                = '0;
    w_occ_span[NUM_SLOTS-1:0] = r_occ;
  end

  assign w_exit_ok = bus.exit_req & w_occ_span[bus.exit_slot];

  always_comb begin
    w_occ_post = r_occ;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_exit_ok && (bus.exit_slot == IDX_W'(i))) begin
        w_occ_post[i] = 1'b0;
      end
    end
  end

`ifdef PARK_RESERVE_EN
  localparam logic [NUM_SLOTS-1:0] RSV_MASK = {1'b1, {(NUM_SLOTS-1){1'b0}}};

  always_comb begin
    if (bus.entry_vip && !w_occ_post[NUM_SLOTS-1]) begin
      w_cand = RSV_MASK;
    end else begin
      w_cand = ~w_occ_post & ~RSV_MASK;
    end
  end

  assign w_lot_full = &r_occ[NUM_SLOTS-2:0];
`else
  logic unused_vip;
  assign unused_vip = bus.entry_vip;
  assign w_cand     = ~w_occ_post;
  assign w_lot_full = &r_occ;
`endif

  always_comb begin
    w_grant_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_grant_idx = IDX_W'(i);
      end
    end
  end

  assign w_grant_ok = |w_cand;

  always_comb begin
    w_free = CNT_W'(NUM_SLOTS);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_free = w_free - CNT_W'(r_occ[i]);
    end
  end

  // Exits are honoured in both states; entries only in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_acnt_nxt  = r_acnt;
    w_occ_nxt   = w_occ_post;
    w_ack_nxt   = 1'b0;
    w_slot_nxt  = '0;
    w_err_nxt   = bus.exit_req & ~w_exit_ok;
    case (r_state)
      IDLE: begin
        if (bus.entry_req) begin
          if (w_grant_ok) begin
            w_occ_nxt  = w_occ_post | (NUM_SLOTS'(1) << w_grant_idx);
            w_ack_nxt  = 1'b1;
            w_slot_nxt = w_grant_idx;
          end else begin
            w_state_nxt = ALARM;
            w_acnt_nxt  = ACNT_W'(ALARM_CYCLES);
          end
        end
      end
      ALARM: begin
        w_acnt_nxt = r_acnt - ACNT_W'(1);
        if (r_acnt <= ACNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_acnt_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_acnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_acnt  <= '0;
      r_occ   <= '0;
      r_ack   <= 1'b0;
      r_slot  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acnt  <= w_acnt_nxt;
      r_occ   <= w_occ_nxt;
      r_ack   <= w_ack_nxt;
      r_slot  <= w_slot_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.entry_ack      = r_ack;
  assign bus.entry_slot     = r_slot;
  assign bus.exit_err       = r_err;
  assign bus.slot_available = ~r_occ;
  assign bus.free_count     = w_free;
  assign bus.lot_full       = w_lot_full;
  assign bus.buzzer         = (r_state == ALARM);

endmodule

`default_nettype wire

// File: tb/tb_park_slot_manager.sv
// +----------------------------------------------------------------------------+
// | tb_park_slot_manager : directed self-checking bench for park_slot_manager  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_park_slot_manager;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  park_slot_manager_if #(.NUM_SLOTS(8))  ifa ();
  park_slot_manager_if #(.NUM_SLOTS(10)) ifb ();

  park_slot_manager #(.NUM_SLOTS(8), .ALARM_CYCLES(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  park_slot_manager #(.NUM_SLOTS(10), .ALARM_CYCLES(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests on the 8-slot unit, then sample 1 time unit after the edge.
  task automatic step_a(input logic ent, input logic ext, input logic [2:0] slot);
    ifa.entry_req = ent;
    ifa.exit_req  = ext;
    ifa.exit_slot = slot;
    @(posedge clk);
    #1;
    ifa.entry_req = 1'b0;
    ifa.exit_req  = 1'b0;
    ifa.exit_slot = '0;
  endtask

  task automatic step_b(input logic ent, input logic ext, input logic [3:0] slot);
    ifb.entry_req = ent;
    ifb.exit_req  = ext;
    ifb.exit_slot = slot;
    @(posedge clk);
    #1;
    ifb.entry_req = 1'b0;
    ifb.exit_req  = 1'b0;
    ifb.exit_slot = '0;
  endtask

  initial begin
    int buzz_cnt;
    int ack_seen;

    ifa.entry_req = 1'b0; ifa.entry_vip = 1'b0; ifa.exit_req = 1'b0; ifa.exit_slot = '0;
    ifb.entry_req = 1'b0; ifb.entry_vip = 1'b0; ifb.exit_req = 1'b0; ifb.exit_slot = '0;

    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ack",   32'(ifa.entry_ack),      32'd0);
    check_val("rst_slot",  32'(ifa.entry_slot),     32'd0);
    check_val("rst_err",   32'(ifa.exit_err),       32'd0);
    check_val("rst_buzz",  32'(ifa.buzzer),         32'd0);
    check_val("rst_avail", 32'(ifa.slot_available), 32'hFF);
    check_val("rst_free",  32'(ifa.free_count),     32'd8);
    check_val("rst_full",  32'(ifa.lot_full),       32'd0);
    check_val("rst_freeb", 32'(ifb.free_count),     32'd10);
    @(negedge clk);
    rst = 1'b1;

    // First entry goes to slot 0 with one cycle of latency.
    step_a(1'b1, 1'b0, 3'd0);
    check_val("e0_ack",   32'(ifa.entry_ack),      32'd1);
    check_val("e0_slot",  32'(ifa.entry_slot),     32'd0);
    check_val("e0_free",  32'(ifa.free_count),     32'd7);
    check_val("e0_avail", 32'(ifa.slot_available), 32'hFE);
    step_a(1'b0, 1'b0, 3'd0);
    check_val("e0_pulse", 32'(ifa.entry_ack),      32'd0);
    check_val("e0_slotz", 32'(ifa.entry_slot),     32'd0);

    for (int i = 1; i < 8; i++) begin
      step_a(1'b1, 1'b0, 3'd0);
      check_val("fill_slot", 32'(ifa.entry_slot), 32'(i));
    end
    check_val("full_free",  32'(ifa.free_count),     32'd0);
    check_val("full_flag",  32'(ifa.lot_full),       32'd1);
    check_val("full_avail", 32'(ifa.slot_available), 32'h00);

    // Full lot: alarm for 4 cycles; entry in alarm ignored, exit in alarm honoured.
    step_a(1'b1, 1'b0, 3'd0);
    check_val("al_ack",  32'(ifa.entry_ack), 32'd0);
    check_val("al_buzz", 32'(ifa.buzzer),    32'd1);
    buzz_cnt = 0;
    ack_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (ifa.buzzer) buzz_cnt++;
      step_a(k == 1, k == 2, 3'd0);
      if (ifa.entry_ack) ack_seen++;
    end
    check_val("al_len",   32'(buzz_cnt),          32'd4);
    check_val("al_noack", 32'(ack_seen),          32'd0);
    check_val("al_exit",  32'(ifa.free_count),    32'd1);
    check_val("al_avail", 32'(ifa.slot_available), 32'h01);

    step_a(1'b1, 1'b0, 3'd0);
    check_val("refill_slot", 32'(ifa.entry_slot), 32'd0);

    // Same-cycle exit of slot 3 on a full lot hands slot 3 to the entry.
    step_a(1'b1, 1'b1, 3'd3);
    check_val("sim_ack",  32'(ifa.entry_ack),  32'd1);
    check_val("sim_slot", 32'(ifa.entry_slot), 32'd3);
    check_val("sim_free", 32'(ifa.free_count), 32'd0);
    check_val("sim_buzz", 32'(ifa.buzzer),     32'd0);
    check_val("sim_err",  32'(ifa.exit_err),   32'd0);

    step_a(1'b0, 1'b1, 3'd5);
    check_val("x5_free",  32'(ifa.free_count),     32'd1);
    check_val("x5_avail", 32'(ifa.slot_available), 32'h20);
    step_a(1'b0, 1'b1, 3'd5);
    check_val("x5_err",   32'(ifa.exit_err),       32'd1);
    check_val("x5_keep",  32'(ifa.slot_available), 32'h20);
    step_a(1'b0, 1'b1, 3'd2);
    check_val("x5_pulse", 32'(ifa.exit_err),       32'd0);
    check_val("x2_avail", 32'(ifa.slot_available), 32'h24);
    step_a(1'b1, 1'b0, 3'd0);
    check_val("low_slot", 32'(ifa.entry_slot),     32'd2);
    step_a(1'b1, 1'b0, 3'd0);
    check_val("nxt_slot", 32'(ifa.entry_slot),     32'd5);

    // Ten-slot unit: slot 9 is a legal index, slot 12 is not.
    for (int i = 0; i < 10; i++) begin
      step_b(1'b1, 1'b0, 4'd0);
    end
    check_val("b_last", 32'(ifb.entry_slot), 32'd9);
    check_val("b_free", 32'(ifb.free_count), 32'd0);
    step_b(1'b0, 1'b1, 4'd9);
    check_val("b_x9_err",   32'(ifb.exit_err),       32'd0);
    check_val("b_x9_avail", 32'(ifb.slot_available), 32'h200);
    step_b(1'b0, 1'b1, 4'd12);
    check_val("b_x12_err",  32'(ifb.exit_err),       32'd1);
    check_val("b_x12_keep", 32'(ifb.slot_available), 32'h200);

    // Reset in the second alarm cycle aborts everything.
    step_a(1'b1, 1'b0, 3'd0);
    check_val("ra_buzz", 32'(ifa.buzzer), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("ra_buzz0", 32'(ifa.buzzer),         32'd0);
    check_val("ra_free",  32'(ifa.free_count),     32'd8);
    check_val("ra_avail", 32'(ifa.slot_available), 32'hFF);
    @(negedge clk);
    rst = 1'b1;
    buzz_cnt = 0;
    ack_seen = 0;
    for (int k = 0; k < 6; k++) begin
      step_a(1'b0, 1'b0, 3'd0);
      if (ifa.buzzer)    buzz_cnt++;
      if (ifa.entry_ack) ack_seen++;
    end
    check_val("ra_nobuzz", 32'(buzz_cnt), 32'd0);
    check_val("ra_noack",  32'(ack_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
